video_dram_req: RTL and testbench

VIDEO_DRAM_REQ -- requirements
Module: video_dram_req

---
 rtl/video_dram_req.sv | 125 ++++++++++++
 tb/tb_video_dram_req.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/video_dram_req.sv
// Video line fetch requester: issues up to four outstanding DRAM word reads per line
// and tracks returned words into 32-bit fetch pairs. Option: VIDEO_DRAM_REQ_WRAP_EN (page-wrapped addressing).
module video_dram_req (
  input  logic        clk,
  input  logic        res,
  input  logic        line_start,
  input  logic [20:0] line_addr,
  input  logic [7:0]  word_cnt,
  output logic        video_go,
  output logic [20:0] video_addr,
  input  logic        video_next,
  input  logic        video_strobe,
  output logic [3:0]  f_sel,
  output logic [1:0]  b_sel,
  output logic        fetch_stb,
  output logic        busy,
  output logic        line_done,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [20:0] addr_reg, addr_next, addr_inc;
  logic [7:0]  remaining_reg, remaining_next;
  logic [2:0]  outstanding_reg, outstanding_next;
  logic        half_reg, half_next;
  logic        fetch_stb_reg, fetch_stb_next;
  logic        line_done_reg, line_done_next;
  logic        proto_err_reg, proto_err_next;
  logic        accept, counted_strobe;

  assign video_go       = (state_reg == REQ) && (remaining_reg != 8'd0) && (outstanding_reg < 3'd4);
  assign accept         = video_go && video_next;
  assign counted_strobe = video_strobe && (outstanding_reg != 3'd0);

`ifdef VIDEO_DRAM_REQ_WRAP_EN
  // Stay inside the 512-word page selected at line start.
  assign addr_inc = {addr_reg[20:9], addr_reg[8:0] + 9'd1};
`else
  assign addr_inc = addr_reg + 21'd1;
`endif

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    remaining_next   = remaining_reg;
    outstanding_next = outstanding_reg;
    half_next        = half_reg;
    fetch_stb_next   = counted_strobe && half_reg;
    line_done_next   = 1'b0;
    proto_err_next   = proto_err_reg || (video_strobe && (outstanding_reg == 3'd0));

    if (accept) begin
      addr_next      = addr_inc;
      remaining_next = remaining_reg - 8'd1;
    end
    if (accept && !counted_strobe)
      outstanding_next = outstanding_reg + 3'd1;
    else if (!accept && counted_strobe)
      outstanding_next = outstanding_reg - 3'd1;
    if (counted_strobe)
      half_next = ~half_reg;

    case (state_reg)
      IDLE: begin
        if (line_start) begin
          if (word_cnt != 8'd0) begin
            state_next     = REQ;
            addr_next      = line_addr;
            remaining_next = word_cnt;
            half_next      = 1'b0;
          end else begin
            line_done_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (remaining_reg == 8'd0)
          state_next = DRAIN;
      end
      DRAIN: begin
        // An odd word count leaves a half-filled fetch word; flush it with line_done.
        if (outstanding_reg == 3'd0) begin
          state_next     = IDLE;
          line_done_next = 1'b1;
          fetch_stb_next = half_reg;
          half_next      = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      half_reg        <= 1'b0;
      fetch_stb_reg   <= 1'b0;
      line_done_reg   <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      outstanding_reg <= outstanding_next;
      half_reg        <= half_next;
      fetch_stb_reg   <= fetch_stb_next;
      line_done_reg   <= line_done_next;
      proto_err_reg   <= proto_err_next;
    end
  end

  assign video_addr = addr_reg;
  assign f_sel      = half_reg ? 4'b1100 : 4'b0011;
  assign b_sel      = 2'b10;
  assign fetch_stb  = fetch_stb_reg;
  assign busy       = (state_reg != IDLE);
  assign line_done  = line_done_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_video_dram_req.sv
// Self-checking bench for video_dram_req: scoreboard of expected request addresses
// and f_sel values, plus directed reset / protocol-error checks.
module tb_video_dram_req;

  logic        clk;
  logic        res;
  logic        line_start;
  logic [20:0] line_addr;
  logic [7:0]  word_cnt;
  logic        video_go;
  logic [20:0] video_addr;
  logic        video_next;
  logic        video_strobe;
  logic [3:0]  f_sel;
  logic [1:0]  b_sel;
  logic        fetch_stb;
  logic        busy;
  logic        line_done;
  logic        proto_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] exp_addr[$];
  logic [3:0]  exp_fsel[$];

  video_dram_req dut (
    .clk(clk), .res(res), .line_start(line_start), .line_addr(line_addr),
    .word_cnt(word_cnt), .video_go(video_go), .video_addr(video_addr),
    .video_next(video_next), .video_strobe(video_strobe), .f_sel(f_sel),
    .b_sel(b_sel), .fetch_stb(fetch_stb), .busy(busy), .line_done(line_done),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] next_addr(input logic [20:0] a);
`ifdef VIDEO_DRAM_REQ_WRAP_EN
    logic [8:0] lo;
    lo = a[8:0] + 9'd1;
    return {a[20:9], lo};
`else
    return a + 21'd1;
`endif
  endfunction

  // Runs one line: accepts whenever allowed (after 'hold' cycles), returns data
  // 'lat' cycles after each accept; stall4 delays the first four returns so the
  // outstanding limit is reached; poke fires an extra line_start mid-line.
  task automatic run_line(input logic [20:0] a, input logic [7:0] n, input int hold,
                          input bit stall4, input int lat, input bit poke);
    logic [20:0] ea;
    int accepts, mout, fetches, dones, pend[$];
    bit prev_full, done;
    ea = a;
    accepts = 0; mout = 0; fetches = 0; dones = 0; prev_full = 0; done = 0;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(ea);
      exp_fsel.push_back((i % 2) ? 4'b1100 : 4'b0011);
      ea = next_addr(ea);
    end
    @(negedge clk);
    line_start = 1'b1; line_addr = a; word_cnt = n;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      line_start = 1'b0; video_next = 1'b0; video_strobe = 1'b0;
      if (t == 0 && n != 8'd0) check("busy_on", busy, 1);
      if (fetch_stb) fetches++;
      if (line_done) begin
        dones++;
        done = 1;
        check("flush_with_done", fetch_stb, n[0]);
        check("busy_off", busy, 0);
      end
      if (mout == 4) check("go_full", video_go, 0);
      if (prev_full && accepts < int'(n)) check("go_resume", video_go, 1);
      prev_full = 0;
      if (pend.size() > 0 && pend[0] <= t) begin
        void'(pend.pop_front());
        video_strobe = 1'b1;
        if (exp_fsel.size() == 0) check("extra_strobe", 1, 0);
        else check("f_sel", f_sel, exp_fsel.pop_front());
        check("b_sel", b_sel, 2'b10);
        prev_full = (mout == 4);
      end
      if (t < hold && n != 8'd0) begin
        check("go_hold", video_go, 1);
        check("addr_hold", video_addr, a);
      end else if (video_go && !done) begin
        if (exp_addr.size() == 0) check("extra_req", 1, 0);
        else check("video_addr", video_addr, exp_addr.pop_front());
        video_next = 1'b1;
        accepts++;
        pend.push_back((stall4 && accepts <= 4) ? t + lat + 8 : t + lat);
      end
      if (poke && t == 3) begin
        line_start = 1'b1; line_addr = 21'h0abcde; word_cnt = 8'd9;
      end
      mout = mout + int'(video_next) - int'(video_strobe);
    end
    if (!done) check("line_done_timeout", 0, 1);
    video_next = 1'b0; video_strobe = 1'b0; line_start = 1'b0;
    check("accepts", accepts, n);
    check("fetch_count", fetches, (int'(n) + 1) / 2);
    check("done_count", dones, 1);
    check("sb_empty", exp_addr.size() + exp_fsel.size(), 0);
    check("proto_clean", proto_err, 0);
    exp_addr.delete(); exp_fsel.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_go"}, video_go, 0);
    check({pfx, "_addr"}, video_addr, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, line_done, 0);
    check({pfx, "_fetch"}, fetch_stb, 0);
    check({pfx, "_proto"}, proto_err, 0);
    check({pfx, "_fsel"}, f_sel, 4'b0011);
    check({pfx, "_bsel"}, b_sel, 2'b10);
  endtask

  initial begin
    int dones, fetches;
    res = 1'b1; line_start = 1'b0; line_addr = '0; word_cnt = '0;
    video_next = 1'b0; video_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    res = 1'b0;

    run_line(21'h00100, 8'd4, 0, 1'b0, 2, 1'b0);
    run_line(21'h02000, 8'd6, 5, 1'b1, 2, 1'b0);
    run_line(21'h00300, 8'd3, 0, 1'b0, 2, 1'b0);
    run_line(21'h001FE, 8'd4, 0, 1'b0, 2, 1'b0);
    run_line(21'h1FFFFE, 8'd4, 0, 1'b0, 2, 1'b0);
    run_line(21'h00040, 8'd0, 0, 1'b0, 2, 1'b0);
    run_line(21'h00500, 8'd5, 0, 1'b0, 2, 1'b1);
    run_line(21'h0F3A7, 8'd7, 2, 1'b0, 3, 1'b0);

    // Reset mid-line after two accepts; strobe during reset must be ignored.
    @(negedge clk);
    line_start = 1'b1; line_addr = 21'h00777; word_cnt = 8'd8;
    @(negedge clk);
    line_start = 1'b0;
    check("mid_go1", video_go, 1);
    video_next = 1'b1;
    @(negedge clk);
    check("mid_go2", video_go, 1);
    @(negedge clk);
    video_next = 1'b0; res = 1'b1; video_strobe = 1'b1;
    @(negedge clk);
    res = 1'b0; video_strobe = 1'b0;
    check_reset_outputs("midrst");
    dones = 0; fetches = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (line_done) dones++;
      if (fetch_stb) fetches++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_no_fetch", fetches, 0);
    check("midrst_no_proto", proto_err, 0);

    // Strobe with nothing outstanding sets the sticky error.
    video_strobe = 1'b1;
    @(negedge clk);
    video_strobe = 1'b0;
    check("proto_set", proto_err, 1);
    repeat (3) @(negedge clk);
    check("proto_sticky", proto_err, 1);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check("proto_clear", proto_err, 0);

    run_line(21'h00010, 8'd2, 0, 1'b0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
